sema_mailbox: RTL

SEMA_MAILBOX -- requirements
Module: sema_mailbox

---
 rtl/sema_pkg.sv | 23 ++
 rtl/sema_fifo.sv | 78 +++++++
 rtl/sema_mailbox.sv | 131 +++++++++++++
 3 files changed

// File: rtl/sema_pkg.sv
// Shared types and elaboration helpers for the semaphore mailbox.
package sema_pkg;

  typedef enum logic [1:0] {
    SEMA_FIXED      = 2'd0,
    SEMA_RR         = 2'd1,
    SEMA_CONCURRENT = 2'd2
  } sema_mode_e;

  typedef enum logic {
    SEMA_SIDE_A = 1'b0,
    SEMA_SIDE_B = 1'b1
  } sema_side_e;

  function automatic bit sema_is_pow2(input int v);
    return (v > 0) && ((v & (v - 1)) == 0);
  endfunction

  function automatic int sema_lvl_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/sema_fifo.sv
// Single-direction mailbox FIFO: registered level, wrapping pointers, no fall-through.
module sema_fifo
  import sema_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        push,
  input  logic [DATA_W-1:0]           push_data,
  input  logic                        pop,
  output logic [DATA_W-1:0]           data,
  output logic [sema_lvl_w(DEPTH)-1:0] level,
  output logic                        empty,
  output logic                        full
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = sema_lvl_w(DEPTH);

  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]  level_q, level_d;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic              push_ok_s, pop_ok_s;

  // Space and occupancy come only from the registered level.
  assign empty = (level_q == {LVL_W{1'b0}});
  assign full  = (level_q == LVL_W'(DEPTH));
  assign level = level_q;
  assign data  = empty ? {DATA_W{1'b0}} : mem_q[rd_ptr_q];

  // Next-state for pointers and level.
  always_comb begin
    push_ok_s = push & ~full;
    pop_ok_s  = pop & ~empty;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    level_d   = level_q;
    if (push_ok_s) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_ok_s) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_ok_s, pop_ok_s})
      2'b10:   level_d = level_q + LVL_W'(1);
      2'b01:   level_d = level_q - LVL_W'(1);
      default: level_d = level_q;
    endcase
  end

  // Pointer and level state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= {PTR_W{1'b0}};
      rd_ptr_q <= {PTR_W{1'b0}};
      level_q  <= {LVL_W{1'b0}};
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Payload storage; contents are meaningless once the level is cleared.
  always_ff @(posedge clk) begin
    if (push_ok_s) begin
      mem_q[wr_ptr_q] <= push_data;
    end
  end

endmodule

// File: rtl/sema_mailbox.sv
// Two-CPU mailbox: one FIFO per direction with configurable write arbitration and drop pulses.
module sema_mailbox
  import sema_pkg::*;
#(
  parameter int         DATA_W = 8,
  parameter int         DEPTH  = 4,
  parameter sema_mode_e MODE   = SEMA_FIXED
) (
  input  logic              clk_s,
  input  logic              rst_s,
  input  logic              sema_write_o_s_A,
  input  logic [DATA_W-1:0] sema_data_o_s_A,
  output logic              sema_is_empty_i_s_A,
  output logic              sema_full_i_s_A,
  output logic              sema_drop_i_s_A,
  output logic [DATA_W-1:0] sema_data_i_s_A,
  output logic              sema_valid_i_s_A,
  input  logic              sema_ready_o_s_A,
  input  logic              sema_write_o_s_B,
  input  logic [DATA_W-1:0] sema_data_o_s_B,
  output logic              sema_is_empty_i_s_B,
  output logic              sema_full_i_s_B,
  output logic              sema_drop_i_s_B,
  output logic [DATA_W-1:0] sema_data_i_s_B,
  output logic              sema_valid_i_s_B,
  input  logic              sema_ready_o_s_B
);

  localparam int LVL_W = sema_lvl_w(DEPTH);

  if (DATA_W < 1) begin : g_bad_data_w
    $error("sema_mailbox: DATA_W must be >= 1");
  end
  if ((DEPTH < 2) || !sema_is_pow2(DEPTH)) begin : g_bad_depth
    $error("sema_mailbox: DEPTH must be a power of two >= 2");
  end

  logic              grant_a_s, grant_b_s, collide_s;
  logic              acc_a_s, acc_b_s, pop_ab_s, pop_ba_s;
  logic              drop_a_q, drop_a_d, drop_b_q, drop_b_d;
  sema_side_e        last_win_q, last_win_d;
  logic [DATA_W-1:0] ab_data_s, ba_data_s;
  logic [LVL_W-1:0]  ab_level_s, ba_level_s;
  logic              ab_empty_s, ab_full_s, ba_empty_s, ba_full_s;

  // Arbitration, acceptance and drop decisions for this cycle.
  always_comb begin
    collide_s  = sema_write_o_s_A & sema_write_o_s_B;
    grant_a_s  = 1'b1;
    grant_b_s  = 1'b1;
    last_win_d = last_win_q;
    case (MODE)
      SEMA_FIXED: begin
        grant_b_s = ~sema_write_o_s_A;
      end
      SEMA_RR: begin
        if (collide_s) begin
          grant_a_s  = (last_win_q == SEMA_SIDE_B);
          grant_b_s  = (last_win_q == SEMA_SIDE_A);
          last_win_d = (last_win_q == SEMA_SIDE_B) ? SEMA_SIDE_A : SEMA_SIDE_B;
        end else begin
          last_win_d = last_win_q;
        end
      end
      SEMA_CONCURRENT: begin
        grant_a_s = 1'b1;
        grant_b_s = 1'b1;
      end
      default: begin
        grant_a_s = 1'b1;
        grant_b_s = ~sema_write_o_s_A;
      end
    endcase
    acc_a_s  = sema_write_o_s_A & grant_a_s & ~ab_full_s;
    acc_b_s  = sema_write_o_s_B & grant_b_s & ~ba_full_s;
    drop_a_d = sema_write_o_s_A & ~acc_a_s;
    drop_b_d = sema_write_o_s_B & ~acc_b_s;
    pop_ab_s = ~ab_empty_s & sema_ready_o_s_B;
    pop_ba_s = ~ba_empty_s & sema_ready_o_s_A;
  end

  // Round-robin history and registered drop pulses.
  always_ff @(posedge clk_s or posedge rst_s) begin
    if (rst_s) begin
      last_win_q <= SEMA_SIDE_B;
      drop_a_q   <= 1'b0;
      drop_b_q   <= 1'b0;
    end else begin
      last_win_q <= last_win_d;
      drop_a_q   <= drop_a_d;
      drop_b_q   <= drop_b_d;
    end
  end

  sema_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_fifo_ab (
    .clk       (clk_s),
    .rst       (rst_s),
    .push      (acc_a_s),
    .push_data (sema_data_o_s_A),
    .pop       (pop_ab_s),
    .data      (ab_data_s),
    .level     (ab_level_s),
    .empty     (ab_empty_s),
    .full      (ab_full_s)
  );

  sema_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_fifo_ba (
    .clk       (clk_s),
    .rst       (rst_s),
    .push      (acc_b_s),
    .push_data (sema_data_o_s_B),
    .pop       (pop_ba_s),
    .data      (ba_data_s),
    .level     (ba_level_s),
    .empty     (ba_empty_s),
    .full      (ba_full_s)
  );

  assign sema_is_empty_i_s_A = ab_empty_s;
  assign sema_full_i_s_A     = ab_full_s;
  assign sema_drop_i_s_A     = drop_a_q;
  assign sema_data_i_s_A     = ba_data_s;
  assign sema_valid_i_s_A    = (ba_level_s != {LVL_W{1'b0}});

  assign sema_is_empty_i_s_B = ba_empty_s;
  assign sema_full_i_s_B     = ba_full_s;
  assign sema_drop_i_s_B     = drop_b_q;
  assign sema_data_i_s_B     = ab_data_s;
  assign sema_valid_i_s_B    = (ab_level_s != {LVL_W{1'b0}});

endmodule
